// File: rtl/screen_ram_writer_pkg.sv
// screen_ram_writer_pkg: terminal-wide screen geometry, fill byte, clear FSM states and the
// row/col to text-RAM address mapping shared by the character writer and video scan-out.
package screen_ram_writer_pkg;
    localparam logic YES = 1'b1;
    localparam logic NO = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic LOW = 1'b0;
    localparam int SCREEN_ROWS_DEFAULT = 30;
    localparam int SCREEN_COLS_DEFAULT = 100;
    localparam int ADDR_WIDTH_DEFAULT = 12;
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h20;
    localparam int ROW_WIDTH = 5;
    localparam int COL_WIDTH = 7;
    localparam int BYTE_WIDTH = 8;
    typedef enum logic {CLEAR, IDLE} state_t;
    // cols is always a constant at the call site, so the multiply reduces to shift/add
    function automatic logic [15:0] screen_address(input logic [ROW_WIDTH-1:0] row,
                                                   input logic [COL_WIDTH-1:0] col,
                                                   input int cols);
        return 16'(row) * 16'(cols) + 16'(col);
    endfunction
endpackage

// File: rtl/screen_ram_writer_if.sv
// screen_ram_writer_if: character write stream (valid/ready, row, col, byte) into the screen RAM writer.
interface screen_ram_writer_if;
    import screen_ram_writer_pkg::*;
    logic write_valid;
    logic write_ready;
    logic [ROW_WIDTH-1:0] write_row;
    logic [COL_WIDTH-1:0] write_col;
    logic [BYTE_WIDTH-1:0] write_byte;
    modport master(output write_valid, write_row, write_col, write_byte, input write_ready);
    modport slave(input write_valid, write_row, write_col, write_byte, output write_ready);
endinterface

// File: rtl/screen_ram_writer.sv
// screen_ram_writer: maps (row, col) writes to registered text-RAM strobes and
// fills the whole RAM with FILL_BYTE after reset or on clear_request.
module screen_ram_writer
    import screen_ram_writer_pkg::*;
#(
    parameter int SCREEN_ROWS = SCREEN_ROWS_DEFAULT,
    parameter int SCREEN_COLS = SCREEN_COLS_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic clk,
    input  logic reset_low,
    screen_ram_writer_if.slave wr,
    input  logic clear_request,
    output logic clear_busy,
    output logic dropped,
    output logic ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0] ram_data
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SCREEN_ROWS * SCREEN_COLS - 1);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [7:0] ram_data_q, ram_data_d;
    logic ram_write_enable_q, ram_write_enable_d;
    logic dropped_q, dropped_d;
    logic accept, in_range, write_hit;
    // accept is decoded from state_q directly so it never depends on the write_ready output
    assign accept = wr.write_valid && state_q == IDLE;
    assign in_range = int'(wr.write_row) < SCREEN_ROWS && int'(wr.write_col) < SCREEN_COLS;
    assign write_hit = accept && in_range;
    assign ram_write_enable = ram_write_enable_q;
    assign ram_address = ram_address_q;
    assign ram_data = ram_data_q;
    assign dropped = dropped_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q <= CLEAR;
            clear_addr_q <= '0;
            dropped_q <= NO;
            ram_write_enable_q <= LOW;
            ram_address_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q <= state_d;
            clear_addr_q <= clear_addr_d;
            dropped_q <= dropped_d;
            ram_write_enable_q <= ram_write_enable_d;
            ram_address_q <= ram_address_d;
            ram_data_q <= ram_data_d;
        end
    end

    // a request restarts the fill from address 0 in either state
    always_comb begin
        state_d = state_q;
        clear_addr_d = clear_addr_q;
        if (clear_request) begin
            state_d = CLEAR;
            clear_addr_d = '0;
        end else if (state_q == CLEAR) begin
            state_d = clear_addr_q == LAST_ADDR ? IDLE : CLEAR;
            clear_addr_d = clear_addr_q == LAST_ADDR ? '0 : clear_addr_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        wr.write_ready = state_q == IDLE ? HIGH : LOW;
        clear_busy = state_q == CLEAR ? HIGH : LOW;
        ram_write_enable_d = state_q == CLEAR || write_hit ? HIGH : LOW;
        ram_address_d = state_q == CLEAR ? clear_addr_q
                      : write_hit ? ADDR_WIDTH'(screen_address(wr.write_row, wr.write_col, SCREEN_COLS))
                      : ram_address_q;
        ram_data_d = state_q == CLEAR ? FILL_BYTE : write_hit ? wr.write_byte : ram_data_q;
        dropped_d = accept && !in_range ? YES : dropped_q;
    end
endmodule

// File: doc/screen_ram_writer.md
Name: screen_ram_writer

Overview:
- Downstream consumer of the character writer's write stream (`write_valid`/`write_ready`, row, col, byte).
- Maps each (row, col) to a linear text-RAM address and issues registered single-port write strobes to the screen text RAM read by the video scan-out.
- Owns screen clear: fills the whole RAM with a fill byte after reset and on request. Upstream writes are stalled while a clear runs.

Parameters:
- SCREEN_ROWS, 30, visible rows; rows >= SCREEN_ROWS are dropped.
- SCREEN_COLS, 100, columns per row; cols >= SCREEN_COLS are dropped.
- ADDR_WIDTH, 12, RAM address width; must satisfy SCREEN_ROWS*SCREEN_COLS <= 2**ADDR_WIDTH.
- FILL_BYTE, 8'h20, byte written during clear (space).

Ports:
- clk  input  1  system clock
- reset_low  input  1  asynchronous, active-low reset
- write_ready  output  1  high when a write can be accepted
- write_valid  input  1  upstream write request
- write_row  input  5  target row
- write_col  input  7  target column
- write_byte  input  8  character code
- clear_request  input  1  single-cycle pulse: clear the screen
- clear_busy  output  1  high while the clear FSM runs
- dropped  output  1  sticky; set when an out-of-range write is accepted, cleared only by reset
- ram_write_enable  output  1  RAM write strobe, registered
- ram_address  output  ADDR_WIDTH  RAM address, registered
- ram_data  output  8  RAM write data, registered

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - state = CLEAR, clear_addr = 0, dropped = 0
  - ram_write_enable = 0, ram_address = 0, ram_data = 0
  - write_ready = 0, clear_busy = 1
- States:
  - CLEAR: write_ready = 0, clear_busy = 1.
  - IDLE: write_ready = 1, clear_busy = 0.
  - write_ready and clear_busy are decoded from the state register only, never from inputs.
- Handshake: a write is accepted in a cycle where write_valid && write_ready. Upstream holds row/col/byte stable until accepted.
- Accepted in-range write (row < SCREEN_ROWS, col < SCREEN_COLS), accepted at cycle N:
  - At N+1: ram_write_enable = 1, ram_address = row*SCREEN_COLS + col, ram_data = write_byte.
  - Latency is exactly 1 cycle; throughput is 1 write per cycle.
- Accepted out-of-range write: consumed with no RAM strobe; dropped is set at N+1.
- Address arithmetic:
  - Computed at ADDR_WIDTH bits, zero-extended from row/col.
  - The multiply by SCREEN_COLS is a constant multiply (shift/add); no DSP required.
- CLEAR sequence:
  - Each cycle: ram_write_enable = 1, ram_address = clear_addr, ram_data = FILL_BYTE (registered, 1-cycle lag from clear_addr), then clear_addr increments.
  - After clear_addr = SCREEN_ROWS*SCREEN_COLS-1 is issued, state moves to IDLE.
  - A full clear issues exactly SCREEN_ROWS*SCREEN_COLS strobes (3000 at defaults).
  - First strobe is at the cycle after reset deassertion or after the request cycle.
- IDLE:
  - clear_request: state -> CLEAR, clear_addr = 0 next cycle.
  - clear_request and write_valid in the same cycle: the write is still accepted (write_ready was high) and its strobe is issued at N+1. The clear starts at N+1, with its first fill strobe at N+2, so the clear overwrites it.
- clear_request while in CLEAR: restart, clear_addr = 0 next cycle; no strobe is skipped or duplicated beyond the restart.
- ram_write_enable is low in any IDLE cycle without an accepted in-range write in the previous cycle.
- Reset mid-clear or mid-write: outputs return to reset values immediately; the pending strobe is lost and the clear restarts from 0 after release.

Decomposition:
- Shared package (terminal-wide, reused by character_writer and video scan-out):
  - YES/NO/HIGH/LOW constants
  - SCREEN_ROWS, SCREEN_COLS, FILL_BYTE defaults
  - state enum typedef {CLEAR, IDLE}
- No sub-module needed; the address multiply is an inline function in the package (screen_address(row, col)).

Test Plan:
- Release reset, hold write_valid=1 -> write_ready=0 for exactly 3000 cycles; strobes at addresses 0..2999 with data 8'h20; then write_ready=1, clear_busy=0.
- After clear, write (0,0,'A') then (2,99,'B') back-to-back -> strobes at 0/8'h41 and 299/8'h42 on consecutive cycles, each 1 cycle after acceptance.
- Write (29,99,8'h7E) -> address 2999; then write (30,5,8'h41) and (3,100,8'h41) -> accepted, no strobe, dropped=1 and stays 1.
- clear_request in the same cycle as write (1,1,'X') -> strobe 101/8'h58, next cycle strobe 0/8'h20, then 2999 more fills.
- clear_request at clear_addr=1500 -> next strobe address 0; total 3000 fills after the restart before IDLE.
- Assert reset_low mid-clear (async, between edges) -> ram_write_enable drops immediately; after release, full 3000-cycle clear from address 0.
